// File: rtl/alu_control_seq.sv
// ALU/MDU control sequencer: decodes AluOp/funct to a 4-bit ALU code and
// sequences multi-cycle mult/div with a valid/ready issue handshake.
//
//  state  | meaning
//  IDLE   | ready; single-cycle ops decoded and issued here
//  MUL    | multiply in progress, cnt counts down remaining busy cycles
//  DIV    | divide in progress, cnt counts down remaining busy cycles
//  DONE   | MDU result written to HI/LO this cycle
module alu_control_seq #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       op_valid,
   input  logic [1:0] AluOp,
   input  logic [5:0] funct,
   input  logic       flush,
   output logic       op_ready,
   output logic [3:0] alu_ctrl,
   output logic       ctrl_valid,
   output logic       illegal,
   output logic       mdu_start,
   output logic       mdu_sel,
   output logic       busy,
   output logic       hi_lo_we
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] alu_ctrl_q, alu_ctrl_d;
   logic       illegal_q, illegal_d;
   logic       mdu_sel_q, mdu_sel_d;
   logic       mdu_start_q, mdu_start_d;
   logic       sc_valid_q, sc_valid_d;

   logic [3:0] dec_code;
   logic       dec_illegal;
   logic       dec_mul;
   logic       dec_div;
   logic       accept;

   always_comb begin
      dec_code    = 4'b0000;
      dec_illegal = 1'b0;
      dec_mul     = 1'b0;
      dec_div     = 1'b0;
      case (AluOp)
         2'b00: dec_code = 4'b0010;
         2'b01: dec_code = 4'b0110;
         2'b10: begin
            case (funct)
               6'b100000: dec_code = 4'b0010;
               6'b100010: dec_code = 4'b0110;
               6'b100100: dec_code = 4'b0000;
               6'b100101: dec_code = 4'b0001;
               6'b100110: dec_code = 4'b0011;
               6'b100111: dec_code = 4'b1100;
               6'b101010: dec_code = 4'b0111;
               6'b011000: begin
                  dec_code = 4'b1000;
                  dec_mul  = 1'b1;
               end
               6'b011010: begin
                  dec_code = 4'b1001;
                  dec_div  = 1'b1;
               end
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: begin
            case (funct)
               6'b000000: dec_code = 4'b1111;
               6'b000010: dec_code = 4'b1110;
               6'b000011: dec_code = 4'b1101;
               default:   dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   assign accept = op_valid && (state_q == S_IDLE) && !flush;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_ctrl_d  = alu_ctrl_q;
      illegal_d   = illegal_q;
      mdu_sel_d   = mdu_sel_q;
      mdu_start_d = 1'b0;
      sc_valid_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               alu_ctrl_d = dec_code;
               illegal_d  = dec_illegal;
               if (dec_mul) begin
                  state_d     = S_MUL;
                  cnt_d       = MUL_LOAD;
                  mdu_start_d = 1'b1;
                  mdu_sel_d   = 1'b0;
               end else if (dec_div) begin
                  state_d     = S_DIV;
                  cnt_d       = DIV_LOAD;
                  mdu_start_d = 1'b1;
                  mdu_sel_d   = 1'b1;
               end else begin
                  sc_valid_d = 1'b1;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd0) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         alu_ctrl_q  <= 4'b0000;
         illegal_q   <= 1'b0;
         mdu_sel_q   <= 1'b0;
         mdu_start_q <= 1'b0;
         sc_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_ctrl_q  <= alu_ctrl_d;
         illegal_q   <= illegal_d;
         mdu_sel_q   <= mdu_sel_d;
         mdu_start_q <= mdu_start_d;
         sc_valid_q  <= sc_valid_d;
      end
   end

   // A flush landing on DONE must suppress the write in that same cycle.
   assign hi_lo_we   = (state_q == S_DONE) && !flush;
   assign ctrl_valid = sc_valid_q || hi_lo_we;
   assign op_ready   = (state_q == S_IDLE);
   assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
   assign alu_ctrl   = alu_ctrl_q;
   assign illegal    = illegal_q;
   assign mdu_sel    = mdu_sel_q;
   assign mdu_start  = mdu_start_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: cycle-timeline reference model with a per-cycle
// compare, plus directed scenarios carrying literal expectations.
module tb_alu_control_seq;

   localparam int MUL_N = 4;
   localparam int DIV_N = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       op_valid = 1'b0;
   logic [1:0] AluOp = 2'b00;
   logic [5:0] funct = 6'd0;
   logic       flush = 1'b0;
   logic       op_ready;
   logic [3:0] alu_ctrl;
   logic       ctrl_valid;
   logic       illegal;
   logic       mdu_start;
   logic       mdu_sel;
   logic       busy;
   logic       hi_lo_we;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   alu_control_seq #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .AluOp(AluOp),
      .funct(funct), .flush(flush), .op_ready(op_ready), .alu_ctrl(alu_ctrl),
      .ctrl_valid(ctrl_valid), .illegal(illegal), .mdu_start(mdu_start),
      .mdu_sel(mdu_sel), .busy(busy), .hi_lo_we(hi_lo_we)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] R_FUNCT [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                          6'h27, 6'h2A, 6'h18, 6'h1A};
   localparam logic [3:0] R_CODE  [9] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3,
                                          4'hC, 4'h7, 4'h8, 4'h9};
   localparam logic [5:0] S_FUNCT [3] = '{6'h00, 6'h02, 6'h03};
   localparam logic [3:0] S_CODE  [3] = '{4'hF, 4'hE, 4'hD};

   // Returns {is_mul, is_div, illegal, code}.
   function automatic logic [6:0] model_decode(input logic [1:0] a, input logic [5:0] f);
      if (a == 2'd0) return {3'b000, 4'h2};
      if (a == 2'd1) return {3'b000, 4'h6};
      if (a == 2'd2) begin
         for (int i = 0; i < 9; i++)
            if (R_FUNCT[i] == f)
               return {R_CODE[i] == 4'h8, R_CODE[i] == 4'h9, 1'b0, R_CODE[i]};
      end else begin
         for (int i = 0; i < 3; i++)
            if (S_FUNCT[i] == f) return {3'b000, S_CODE[i]};
      end
      return {3'b001, 4'h0};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: events expressed as absolute cycle numbers.
   int cyc = 0;
   int blk_end = -1, start_cyc = -10, busy_end = -10, done_cyc = -10, single_cyc = -10;
   logic [3:0] m_code = 4'h0;
   logic       m_ill = 1'b0, m_sel = 1'b0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         blk_end = -1; start_cyc = -10; busy_end = -10; done_cyc = -10;
         single_cyc = -10; m_code = 4'h0; m_ill = 1'b0; m_sel = 1'b0;
      end else if (clk) begin
         if (cyc > blk_end) begin
            if (op_valid && !flush) begin
               logic [6:0] d;
               int n;
               d = model_decode(AluOp, funct);
               m_code = d[3:0];
               m_ill  = d[4];
               if (d[6] || d[5]) begin
                  n = d[6] ? MUL_N : DIV_N;
                  m_sel = d[5];
                  start_cyc = cyc + 1;
                  busy_end  = cyc + n;
                  done_cyc  = cyc + n + 1;
                  blk_end   = cyc + n + 1;
               end else begin
                  single_cyc = cyc + 1;
               end
            end
         end else if (flush) begin
            blk_end  = cyc;
            busy_end = cyc;
            done_cyc = -10;
         end
         cyc++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
         bit e_done, e_cv;
         e_done = (cyc == done_cyc) && !flush;
         e_cv   = (cyc == single_cyc) || e_done;
         check("op_ready", int'(op_ready), int'(cyc > blk_end));
         check("busy", int'(busy), int'(cyc >= start_cyc && cyc <= busy_end));
         check("mdu_start", int'(mdu_start), int'(cyc == start_cyc));
         check("hi_lo_we", int'(hi_lo_we), int'(e_done));
         check("ctrl_valid", int'(ctrl_valid), int'(e_cv));
         if (e_cv) begin
            check("alu_ctrl", int'(alu_ctrl), int'(m_code));
            check("illegal", int'(illegal), int'(m_ill));
         end
         if (cyc == start_cyc) check("mdu_sel", int'(mdu_sel), int'(m_sel));
      end
   end

   task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic fl);
      op_valid = v; AluOp = a; funct = f; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_alu_ctrl"}, int'(alu_ctrl), 0);
      check({tag, "_ctrl_valid"}, int'(ctrl_valid), 0);
      check({tag, "_illegal"}, int'(illegal), 0);
      check({tag, "_mdu_start"}, int'(mdu_start), 0);
      check({tag, "_mdu_sel"}, int'(mdu_sel), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_hi_lo_we"}, int'(hi_lo_we), 0);
      check({tag, "_op_ready"}, int'(op_ready), 1);
   endtask

   typedef struct { logic [1:0] a; logic [5:0] f; logic [3:0] code; } vec_t;
   vec_t sweep [12] = '{
      '{2'd0, 6'h00, 4'h2}, '{2'd1, 6'h00, 4'h6},
      '{2'd2, 6'h20, 4'h2}, '{2'd2, 6'h22, 4'h6}, '{2'd2, 6'h24, 4'h0},
      '{2'd2, 6'h25, 4'h1}, '{2'd2, 6'h26, 4'h3}, '{2'd2, 6'h27, 4'hC},
      '{2'd2, 6'h2A, 4'h7}, '{2'd3, 6'h00, 4'hF}, '{2'd3, 6'h02, 4'hE},
      '{2'd3, 6'h03, 4'hD}};

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, k, hlw, hk, ak;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_vals("reset");
      chk_en = 1'b1;

      foreach (sweep[i]) begin
         step(1'b1, sweep[i].a, sweep[i].f, 1'b0);
         check("sweep_cv", int'(ctrl_valid), 1);
         check("sweep_code", int'(alu_ctrl), int'(sweep[i].code));
         check("sweep_illegal", int'(illegal), 0);
         check("sweep_ready", int'(op_ready), 1);
      end
      step(1'b0, 2'd0, 6'd0, 1'b0);

      // multiply timeline
      step(1'b1, 2'd2, 6'h18, 1'b0);
      check("mul_start", int'(mdu_start), 1);
      check("mul_sel", int'(mdu_sel), 0);
      check("mul_busy", int'(busy), 1);
      check("mul_ready", int'(op_ready), 0);
      nb = 0;
      while (busy && nb < 300) begin
         nb++;
         step(1'b0, 2'd0, 6'd0, 1'b0);
      end
      check("mul_busy_len", nb, 4);
      check("mul_hlw", int'(hi_lo_we), 1);
      check("mul_code", int'(alu_ctrl), 8);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      check("mul_ready_back", int'(op_ready), 1);

      // divide with add held on op_valid
      step(1'b1, 2'd2, 6'h1A, 1'b0);
      check("div_sel", int'(mdu_sel), 1);
      k = 1; hlw = 0; hk = -1; ak = -1;
      while (k <= 45) begin
         if (hi_lo_we) begin hlw++; hk = k; end
         if (ak > 0 && k == ak + 1) begin
            check("div_add_cv", int'(ctrl_valid), 1);
            check("div_add_code", int'(alu_ctrl), 2);
            break;
         end
         if (op_ready && ak < 0) ak = k;
         step(ak < 0 || ak == k, 2'd2, 6'h20, 1'b0);
         k++;
      end
      step(1'b0, 2'd0, 6'd0, 1'b0);
      check("div_hlw_count", hlw, 1);
      check("div_hlw_cycle", hk, 33);
      check("div_accept_cycle", ak, 34);

      // illegal encodings
      step(1'b1, 2'd3, 6'h07, 1'b0);
      check("ill1_cv", int'(ctrl_valid), 1);
      check("ill1_code", int'(alu_ctrl), 0);
      check("ill1_flag", int'(illegal), 1);
      check("ill1_busy", int'(busy), 0);
      step(1'b1, 2'd2, 6'h3F, 1'b0);
      check("ill2_cv", int'(ctrl_valid), 1);
      check("ill2_code", int'(alu_ctrl), 0);
      check("ill2_flag", int'(illegal), 1);
      check("ill2_busy", int'(busy), 0);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      check("ill_ready", int'(op_ready), 1);

      // flush on 3rd busy cycle of a divide
      step(1'b1, 2'd2, 6'h1A, 1'b0);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      check("flush_busy3", int'(busy), 1);
      step(1'b0, 2'd0, 6'd0, 1'b1);
      check("flush_ready", int'(op_ready), 1);
      check("flush_busy", int'(busy), 0);
      hlw = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 2'd0, 6'd0, 1'b0);
         if (hi_lo_we) hlw++;
      end
      check("flush_no_hlw", hlw, 0);

      // flush landing on DONE of a multiply
      step(1'b1, 2'd2, 6'h18, 1'b0);
      nb = 0;
      while (busy && nb < 300) begin
         nb++;
         step(1'b0, 2'd0, 6'd0, 1'b0);
      end
      flush = 1'b1;
      #1;
      check("done_flush_hlw", int'(hi_lo_we), 0);
      check("done_flush_cv", int'(ctrl_valid), 0);
      @(posedge clk);
      #1 flush = 1'b0;
      check("done_flush_ready", int'(op_ready), 1);

      // flush with op_valid in IDLE
      step(1'b1, 2'd2, 6'h20, 1'b1);
      check("idle_flush_cv", int'(ctrl_valid), 0);
      step(1'b1, 2'd2, 6'h18, 1'b1);
      check("idle_flush_busy", int'(busy), 0);
      check("idle_flush_start", int'(mdu_start), 0);

      // asynchronous reset during a multiply
      step(1'b1, 2'd2, 6'h18, 1'b0);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      check("pre_reset_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check_reset_vals("async");
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      hlw = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 2'd0, 6'd0, 1'b0);
         if (hi_lo_we) hlw++;
      end
      check("reset_no_hlw", hlw, 0);
      step(1'b1, 2'd1, 6'd0, 1'b0);
      check("post_reset_cv", int'(ctrl_valid), 1);
      check("post_reset_code", int'(alu_ctrl), 6);
      step(1'b0, 2'd0, 6'd0, 1'b0);
      step(1'b0, 2'd0, 6'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU/MDU control sequencer for the MIPS datapath, sitting between the main decoder (`AluOp`, `funct`) and the ALU plus multiply/divide unit. It decodes every R-type, I-type and shift operation to a 4-bit ALU control code. It also runs multiply and divide as multi-cycle operations under a valid/ready handshake, stalling the issue stage until HI/LO is written. Unknown encodings are flagged rather than left holding a stale control code.

## Interface
- `MUL_CYCLES`, 4, number of busy cycles for `mult`; legal range 1 to 255.
- `DIV_CYCLES`, 32, number of busy cycles for `div`; legal range 1 to 255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `op_valid`  in  1  decoder presents an operation this cycle.
- `AluOp`  in  2  main-decoder ALU class.
- `funct`  in  6  R-type function field.
- `flush`  in  1  pipeline flush; aborts the in-flight operation.
- `op_ready`  out  1  the block accepts an operation this cycle; equals state==IDLE.
- `alu_ctrl`  out  4  registered ALU control code.
- `ctrl_valid`  out  1  `alu_ctrl`, `mdu_sel` and `illegal` are valid this cycle.
- `illegal`  out  1  the accepted operation had an unknown encoding.
- `mdu_start`  out  1  one-cycle pulse that starts the MDU.
- `mdu_sel`  out  1  MDU operation select: 0 = mult, 1 = div.
- `busy`  out  1  a multi-cycle operation is in progress.
- `hi_lo_we`  out  1  one-cycle HI/LO write enable at completion.

## Operation
- **Accept:** an operation is accepted when `op_valid && op_ready && !flush`.
- **Decode, AluOp 00:** `alu_ctrl` = 0010 (add).
- **Decode, AluOp 01:** `alu_ctrl` = 0110 (sub).
- **Decode, AluOp 10, single-cycle:** add 100000→0010; sub 100010→0110; and 100100→0000; or 100101→0001; xor 100110→0011; nor 100111→1100; slt 101010→0111.
- **Decode, AluOp 10, multi-cycle:** mult 011000→1000; div 011010→1001.
- **Decode, AluOp 11:** sll 000000→1111; srl 000010→1110; sra 000011→1101.
- **Unknown encoding:** any other `AluOp`/`funct` combination gives `alu_ctrl` = 0000 and `illegal` = 1 with `ctrl_valid`. It is treated as single-cycle.
- **States:** IDLE, MUL, DIV, DONE, held in a 2-bit state register. An 8-bit down-counter `cnt` times the multi-cycle states.
- **IDLE, single-cycle accept:** the next cycle has `ctrl_valid` = 1 with the decoded code, and the block stays in IDLE. Back-to-back issue is allowed at one operation per cycle.
- **IDLE, mult/div accept:** go to MUL or DIV, and load `cnt` with `MUL_CYCLES-1` or `DIV_CYCLES-1`. In the first cycle of that state, `mdu_start` = 1 and `mdu_sel` is set.
- **MUL/DIV:** `busy` = 1. `cnt` decrements each cycle; at `cnt`==0 go to DONE.
- **DONE:** `hi_lo_we` = 1, `ctrl_valid` = 1, `alu_ctrl` holds 1000 or 1001, then go to IDLE.
- **Flush in MUL, DIV or DONE:** next state is IDLE. `hi_lo_we` and `ctrl_valid` are forced to 0 in the flush cycle, and `cnt` is cleared.
- **Flush in IDLE:** no operation is accepted. `ctrl_valid` is 0 in the next cycle.
- **Flush with op_valid in the same cycle:** flush wins and the operation is dropped.
- **Registered outputs:** `alu_ctrl`, `mdu_sel` and `illegal` hold their last values when `ctrl_valid` = 0.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `alu_ctrl` 0000, `ctrl_valid` 0, `illegal` 0, `mdu_start` 0, `mdu_sel` 0, `busy` 0, `hi_lo_we` 0. `op_ready` is therefore 1.
- **Single-cycle latency:** accept at edge T; `ctrl_valid` is high in cycle T+1.
- **Multi-cycle timeline:** accept at T. `mdu_start` and `busy` rise in cycle T+1. `busy` lasts N cycles, where N is `MUL_CYCLES` or `DIV_CYCLES`. DONE occurs in cycle T+N+1, and `op_ready` returns in cycle T+N+2.
- **op_ready:** 0 throughout MUL, DIV and DONE; inputs are ignored while `op_ready` = 0.
- **N = 1:** the block spends one cycle in MUL or DIV. That cycle carries both `mdu_start` and `busy`.
- **Reset mid-operation:** all outputs go to their reset values asynchronously. No `hi_lo_we` is produced.

## Test plan
- **Reset and single-cycle sweep:** apply reset, then issue every legal single-cycle encoding back-to-back. Each must produce `ctrl_valid` one cycle later with the listed code, `illegal` = 0 and `op_ready` held at 1.
- **Multiply:** with `MUL_CYCLES` = 4, accept AluOp 10 / funct 011000 at T. Expect `mdu_start` pulse and `mdu_sel` = 0 at T+1, `busy` for T+1..T+4, `hi_lo_we` with `alu_ctrl` 1000 at T+5, and `op_ready` = 1 at T+6.
- **Divide with blocked issue:** with `DIV_CYCLES` = 32, accept a div and keep driving `op_valid` with an add. The add must not be accepted until cycle T+34, and `hi_lo_we` must fire exactly once at T+33.
- **Illegal encodings:** issue AluOp 11 / funct 000111, then AluOp 10 / funct 111111. Each gives `alu_ctrl` 0000 with `illegal` = 1, and neither causes `busy`.
- **Flush:** assert `flush` during the 3rd busy cycle of a div. The block returns to IDLE next cycle with no `hi_lo_we`. Also assert `flush` together with `op_valid` in IDLE; `ctrl_valid` must stay 0.
- **Asynchronous reset mid-multiply:** pulse `reset` between clock edges during a multiply. All outputs clear immediately, without waiting for an edge.
